button_conditioner: RTL and testbench



---
 rtl/button_conditioner_pkg.sv | 20 ++
 rtl/button_conditioner_ch.sv | 126 ++++++++++++
 rtl/button_conditioner.sv | 41 ++++
 tb/tb_button_conditioner.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types, width helper and 25 MHz default timing for the button conditioner.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    HELD     = 2'd1,
    DELAY    = 2'd2,
    REPEAT   = 2'd3
  } rep_state_t;

  // 25 MHz pixel clock: 10 ms debounce, 500 ms first repeat, 100 ms repeat period
  localparam int unsigned DEF_STABLE_CYCLES = 250000;
  localparam int unsigned DEF_REPEAT_DELAY  = 12500000;
  localparam int unsigned DEF_REPEAT_PERIOD = 2500000;

  function automatic int unsigned cnt_w(input int unsigned max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_ch.sv
// One input channel: synchroniser, debounce counter and hold-to-repeat FSM.
// The release strobe is named release_pulse because 'release' is a reserved word.
module button_conditioner_ch
  import button_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter logic        INV           = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic fire
);

  localparam int unsigned DW = cnt_w(STABLE_CYCLES);
  localparam int unsigned RW = cnt_w((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  localparam logic [1:0] S_RELEASED = RELEASED;
  localparam logic [1:0] S_HELD     = HELD;
  localparam logic [1:0] S_DELAY    = DELAY;
  localparam logic [1:0] S_REPEAT   = REPEAT;

  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0]          dcnt;
  logic [RW-1:0]          rcnt;
  logic [RW-1:0]          rcnt_nxt;
  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic                   s;
  logic                   toggle;
  logic                   press_ev;
  logic                   rel_ev;
  logic                   rep_ev;

  // Inversion sits after the flops, so an active-low line reads pressed until flushed
  assign s        = sync[SYNC_STAGES-1] ^ INV;
  assign toggle   = (s != level) && (dcnt == DW'(STABLE_CYCLES - 1));
  assign press_ev = toggle && !level;
  assign rel_ev   = toggle && level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync          <= '0;
      dcnt          <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], raw};
      press         <= press_ev;
      release_pulse <= rel_ev;
      if (s == level) begin
        dcnt <= '0;
      end else if (toggle) begin
        dcnt  <= '0;
        level <= ~level;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  // Release outranks everything; a disable outranks a terminal count
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rep_ev    = 1'b0;
    if (rel_ev) begin
      state_nxt = S_RELEASED;
      rcnt_nxt  = '0;
    end else begin
      case (state)
        S_RELEASED: begin
          if (press_ev) begin
            state_nxt = repeat_en ? S_DELAY : S_HELD;
            rcnt_nxt  = '0;
          end
        end
        S_DELAY: begin
          if (!repeat_en) begin
            state_nxt = S_HELD;
            rcnt_nxt  = '0;
          end else if (rcnt == RW'(REPEAT_DELAY - 1)) begin
            state_nxt = S_REPEAT;
            rcnt_nxt  = '0;
            rep_ev    = 1'b1;
          end else begin
            rcnt_nxt = rcnt + RW'(1);
          end
        end
        S_REPEAT: begin
          if (!repeat_en) begin
            state_nxt = S_HELD;
            rcnt_nxt  = '0;
          end else if (rcnt == RW'(REPEAT_PERIOD - 1)) begin
            rcnt_nxt = '0;
            rep_ev   = 1'b1;
          end else begin
            rcnt_nxt = rcnt + RW'(1);
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RELEASED;
      rcnt  <= '0;
      fire  <= 1'b0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
      fire  <= press_ev | rep_ev;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// N_CH independent button/NES-line conditioners on the pixel clock.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned    N_CH          = 8,
  parameter int unsigned    SYNC_STAGES   = 2,
  parameter int unsigned    STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned    REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned    REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter logic [N_CH-1:0] INVERT       = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in_raw,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] fire
);

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    button_conditioner_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .INV          (INVERT[i])
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .raw          (in_raw[i]),
      .repeat_en    (repeat_en[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .fire         (fire[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: debounce latency, glitches, auto-repeat, active-low, reset.
module tb_button_conditioner;

  localparam int unsigned N_CH = 4;
  localparam logic [3:0]  INV  = 4'b1000;
  localparam int          LAT  = 6;    // SYNC_STAGES + STABLE_CYCLES
  localparam int          RDLY = 10;
  localparam int          RPER = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_raw;
  logic [3:0] repeat_en;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] release_pulse;
  logic [3:0] fire;

  int errors = 0;
  int checks = 0;

  button_conditioner #(
    .N_CH         (N_CH),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3),
    .INVERT       (INV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_raw       (in_raw),
    .repeat_en    (repeat_en),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .fire         (fire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press channel ch for 'hold' cycles, observe 'total' cycles; repeat_en dropped after step 'drop'
  task automatic run_hold(input int ch, input int hold, input int total, input bit rep, input int drop);
    logic act;
    int   rel_k;
    logic e_lvl, e_prs, e_rel, e_fire;
    act   = ~INV[ch];
    rel_k = hold + LAT;
    in_raw[ch] = act;
    for (int k = 1; k <= total; k++) begin
      step();
      e_lvl  = (k >= LAT) && (k < rel_k);
      e_prs  = (k == LAT);
      e_rel  = (k == rel_k);
      e_fire = e_prs || (rep && (k >= LAT + RDLY) && (k < rel_k) && (k <= drop)
                         && (((k - LAT - RDLY) % RPER) == 0));
      chk($sformatf("ch%0d level", ch),   k, 4'(level[ch]),         4'(e_lvl));
      chk($sformatf("ch%0d press", ch),   k, 4'(press[ch]),         4'(e_prs));
      chk($sformatf("ch%0d release", ch), k, 4'(release_pulse[ch]), 4'(e_rel));
      chk($sformatf("ch%0d fire", ch),    k, 4'(fire[ch]),          4'(e_fire));
      if (k == hold) in_raw[ch] = ~act;
      if (k == drop) repeat_en[ch] = 1'b0;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_raw    = 4'b1000;
    repeat_en = 4'b0000;
    #1;
    chk("reset level", 0, level, 4'b0000);
    chk("reset press", 0, press, 4'b0000);
    chk("reset fire",  0, fire,  4'b0000);
    step();
    step();
    rst_n = 1'b1;

    // Idle after reset: active-low channel must not produce a spurious press
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("idle level", k, level, 4'b0000);
      chk("idle press", k, press, 4'b0000);
      chk("idle fire",  k, fire,  4'b0000);
    end

    // Clean press on channel 0, no repeat
    run_hold(0, 20, 30, 1'b0, 1000);

    // Two 3-cycle glitches separated by one low cycle
    in_raw[1] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("glitch level", k, 4'(level[1]), 4'b0);
      chk("glitch press", k, 4'(press[1]), 4'b0);
      chk("glitch fire",  k, 4'(fire[1]),  4'b0);
      if (k == 3 || k == 7) in_raw[1] = 1'b0;
      if (k == 4) in_raw[1] = 1'b1;
    end

    // Auto-repeat on channel 2
    repeat_en[2] = 1'b1;
    run_hold(2, 30, 45, 1'b1, 1000);

    // Repeat disabled at P+11
    repeat_en[2] = 1'b1;
    run_hold(2, 30, 45, 1'b1, LAT + 11);

    // Active-low channel 3
    run_hold(3, 10, 20, 1'b0, 1000);

    // Async reset while channel 2 is in REPEAT
    repeat_en[2] = 1'b1;
    run_hold(2, 1000, 20, 1'b1, 1000);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst level",   0, level,         4'b0000);
    chk("async rst press",   0, press,         4'b0000);
    chk("async rst release", 0, release_pulse, 4'b0000);
    chk("async rst fire",    0, fire,          4'b0000);
    step();
    chk("held rst fire", 0, fire, 4'b0000);
    rst_n = 1'b1;
    run_hold(2, 20, 30, 1'b1, 1000);
    chk("post level3", 0, 4'(level[3]), 4'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
